// File: rtl/sign_arith_pkg.sv
// -----------------------------------------------------------------------------
// sign_arith_pkg
// Shared definitions for the sequential signed/unsigned arithmetic blocks
// (sign_multiplier and its companion divider).
//   state_e    : FSM state encoding shared by both blocks
//   cnt_width(): width of the iteration counter for a W-bit datapath
// -----------------------------------------------------------------------------
package sign_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // One extra bit so the counter can represent W itself.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage : sign_arith_pkg

// File: rtl/cond_negate.sv
// -----------------------------------------------------------------------------
// cond_negate
// Conditional two's-complement negation, purely combinational.
//   value  : input operand (WIDTH bits)
//   neg    : 1 = output -value, 0 = pass value through
//   result : neg ? ~value + 1 : value
// -----------------------------------------------------------------------------
module cond_negate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + WIDTH'(1)) : value;

endmodule : cond_negate

// File: rtl/sign_multiplier.sv
// -----------------------------------------------------------------------------
// sign_multiplier
// Sequential shift-and-add multiply-accumulate:
//   Product = Multiplicand * Multiplier + Addend   (modulo 2^(2W))
// Inverse companion of the divider: feeding Quotient, Divider and Remainder
// rebuilds the Dividend. Sign=0 treats operands as unsigned, Sign=1 as
// two's complement. Latency: W+1 edges from the accepting edge.
//
// Ports
//   Clk          : clock, rising edge
//   ResetN       : synchronous active-low reset
//   Start        : request, accepted only on an edge where Ready=1
//   Sign         : 0 = unsigned, 1 = signed operands
//   Multiplicand : first factor  (W)
//   Multiplier   : second factor (W)
//   Addend       : accumulate term (W), extended according to Sign
//   Ready        : idle and able to accept Start
//   Valid        : one-cycle pulse, Product updated this cycle
//   Product      : 2W-bit result, held until the next result or reset
// -----------------------------------------------------------------------------
module sign_multiplier
  import sign_arith_pkg::*;
#(
  parameter int INPUT_BIT_WIDTH = 8
) (
  input  logic                           Clk,
  input  logic                           ResetN,
  input  logic                           Start,
  input  logic                           Sign,
  input  logic [INPUT_BIT_WIDTH-1:0]     Multiplicand,
  input  logic [INPUT_BIT_WIDTH-1:0]     Multiplier,
  input  logic [INPUT_BIT_WIDTH-1:0]     Addend,
  output logic                           Ready,
  output logic                           Valid,
  output logic [2*INPUT_BIT_WIDTH-1:0]   Product
);

  localparam int W     = INPUT_BIT_WIDTH;
  localparam int CNT_W = cnt_width(W);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [2*W-1:0]     mcand_q,   mcand_d;    // shifted left each iteration
  logic [W-1:0]       mplier_q,  mplier_d;   // shifted right each iteration
  logic [2*W-1:0]     acc_q,     acc_d;
  logic [2*W-1:0]     addend_q,  addend_d;   // already extended to 2W
  logic               neg_q,     neg_d;      // result must be negated
  logic               ready_q,   ready_d;
  logic               valid_q,   valid_d;
  logic [2*W-1:0]     product_q, product_d;

  // ---------------------------------------------------------------------------
  // Operand magnitudes (only meaningful on the accepting edge) and the
  // conditionally negated accumulator used in FIX.
  // ---------------------------------------------------------------------------
  logic [W-1:0]   mcand_mag;
  logic [W-1:0]   mplier_mag;
  logic [2*W-1:0] acc_signed;
  logic           mcand_neg;
  logic           mplier_neg;

  assign mcand_neg  = Sign & Multiplicand[W-1];
  assign mplier_neg = Sign & Multiplier[W-1];

  // The most-negative operand maps to 2^(W-1), which still fits W unsigned
  // bits, so no special case is needed.
  cond_negate #(.WIDTH(W)) u_mcand_mag (
    .value  (Multiplicand),
    .neg    (mcand_neg),
    .result (mcand_mag)
  );

  cond_negate #(.WIDTH(W)) u_mplier_mag (
    .value  (Multiplier),
    .neg    (mplier_neg),
    .result (mplier_mag)
  );

  cond_negate #(.WIDTH(2*W)) u_result_neg (
    .value  (acc_q),
    .neg    (neg_q),
    .result (acc_signed)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // otherwise synthesis would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    addend_d  = addend_q;
    neg_d     = neg_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d  = MUL;
          cnt_d    = '0;
          ready_d  = 1'b0;
          mcand_d  = {{W{1'b0}}, mcand_mag};
          mplier_d = mplier_mag;
          acc_d    = '0;
          neg_d    = mcand_neg ^ mplier_neg;
          addend_d = {{W{Sign & Addend[W-1]}}, Addend};
        end
      end

      MUL: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Fixed latency: all W iterations run even once the multiplier is 0.
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        product_d = acc_signed + addend_q;  // wraps modulo 2^(2W)
        valid_d   = 1'b1;
        ready_d   = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    // NOTE: reset is synchronous (sampled only on the clock edge), so it sits
    // inside the clocked block with no reset term in the sensitivity list.
    if (!ResetN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      addend_q  <= '0;
      neg_q     <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      addend_q  <= addend_d;
      neg_q     <= neg_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      product_q <= product_d;
    end
  end

  assign Ready   = ready_q;
  assign Valid   = valid_q;
  assign Product = product_q;

endmodule : sign_multiplier

// File: doc/sign_multiplier.md
Name: sign_multiplier

Overview:
Sequential shift-and-add multiply-accumulate. It is the inverse companion of the SignDivider and computes Product = Multiplicand*Multiplier + Addend.
- Feeding it Quotient, Divider and Remainder reconstructs the Dividend. The bench uses this for divider round-trip checks.
- Also usable standalone as a low-area signed/unsigned multiplier.
- Same Sign convention as the divider: 0 = unsigned, 1 = two's complement.

Parameters:
INPUT_BIT_WIDTH, 8, width W of Multiplicand, Multiplier and Addend; Product is 2W bits.

Ports:
Clk  input  1  clock; all logic on rising edge
ResetN  input  1  synchronous active-low reset, sampled on rising edge of Clk
Start  input  1  request; accepted only on an edge where Ready=1
Sign  input  1  0 = unsigned operands, 1 = signed two's-complement operands
Multiplicand  input  W  first factor (divider's Quotient)
Multiplier  input  W  second factor (divider's Divider)
Addend  input  W  accumulate term (divider's Remainder)
Ready  output  1  high when idle and able to accept Start
Valid  output  1  one-cycle pulse: Product updated this cycle
Product  output  2W  result, held until the next result or reset

Behaviour:
- Reset (ResetN=0 at an edge): state IDLE, Ready=1, Valid=0, Product=0, internal registers 0. This applies mid-operation too: an in-flight operation is abandoned and no Valid is produced.
- States are IDLE, MUL and FIX.
- IDLE, Ready=1: on an edge with Start=1, latch the following, then go to MUL with counter=0 and Ready=0 from that edge:
  - Sign;
  - the magnitudes |Multiplicand| and |Multiplier|, as W-bit unsigned values, negated only if Sign=1 and the MSB is set;
  - NegResult = Sign & (MSB(Multiplicand) XOR MSB(Multiplier));
  - Addend, extended to 2W bits (sign-extended if Sign=1, else zero-extended).
- Operand and Sign inputs are don't-care except on the accepting edge.
- MUL runs exactly W edges. Each edge: if the multiplier LSB=1, acc += mcand (2W-bit); mcand <<= 1; multiplier >>= 1; counter++. Leave MUL after iteration W-1.
- FIX runs one edge:
  - Product = (NegResult ? -acc : acc) + extended Addend, modulo 2^2W; overflow wraps silently.
  - Valid=1 for the following cycle only. State returns to IDLE and Ready=1.
- Latency: accept at edge k, Product/Valid visible after edge k+W+1 (W=8: 9 cycles). The next Start can be accepted at edge k+W+2.
- Start while Ready=0 (MUL or FIX) is ignored, not queued.
- Start held high continuously: back-to-back operations every W+2 edges.
- Most-negative operand (-2^(W-1)): its magnitude 2^(W-1) fits the W-bit unsigned path. (-128)*(-128) = 0x4000 for W=8; no special case.
- Zero operand: MUL still runs the full W cycles (fixed latency); the result is extended Addend.
- Sign=0: NegResult=0, zero-extension, no negation anywhere.

Decomposition:
- Shared package `sign_arith_pkg` holds:
  - the state encoding constants IDLE=2'd0, MUL=2'd1, FIX=2'd2;
  - the iteration counter width $clog2(W)+1.
- The divider is switched to the same package for its state constants.
- One natural sub-module, `cond_negate`: parameterised width, inputs value and neg, output neg ? ~value+1 : value.
  - Used for operand magnitudes (W) and result negation (2W).
  - The divider reuses it.

Test Plan:
- Unsigned round-trip: Sign=0, Multiplicand=6, Multiplier=2, Addend=1, Start pulse → Product=0x000D, Valid high exactly 9 cycles after the accepting edge, Ready low in between.
- Signed round-trip: Sign=1, Multiplicand=0xFA (-6), Multiplier=0x02, Addend=0xFF (-1) → Product=0xFFF3 (-13). Repeat Sign=0 with the same bits → 0x01F4+0x00FF=0x02F3.
- Extremes: Sign=1, 0x80*0x80, Addend=0 → 0x4000. Sign=0, 0xFF*0xFF, Addend=0xFF → 0xFF00. Sign=1, 0x80*0x7F → 0xC080.
- Start while busy: second Start with different operands 3 cycles after accept → ignored, first result delivered unchanged, single Valid pulse.
- Reset mid-operation: ResetN=0 for one edge during MUL → next cycle Ready=1, Valid=0, Product=0. A following operation 5*5+0 → 0x0019 with normal latency.
- Divider loop: random 500 pairs through SignDivider and then sign_multiplier (Quotient, Divider, Remainder) for both Sign values, Divider≠0 → Product low W bits equal the original Dividend.
